keypad_code_entry: RTL and testbench

Downstream consumer of the keypad scanner/decoder in the control center. It synchronizes and debounces the decoded key code and accepts one press per physical keystroke. It assembles a 4-digit PIN, compares it against a parameterized access code, and reports grant/deny. After repeated failures it enforces a lockout. The entered digits are exported for the 7-segment display multiplexer.

---
 rtl/keypad_code_entry.sv | 252 +++++++++++++++++++++++++
 tb/tb_keypad_code_entry.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_entry.sv
// Keypad PIN entry: synchronise and debounce decoded keys, assemble a 4-digit code, grant/deny, lockout after repeated failures.
// Latency: strobe DEBOUNCE_CYCLES+2 edges after a stable press; digit buffer one cycle later; grant/deny two cycles after ENTER strobe.
// Backpressure: none; inputs are level-sampled, keys arriving during CHECK or LOCKOUT are dropped, never queued.
module keypad_code_entry #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [15:0] CODE            = 16'h1234,
    parameter int          MAX_FAILS       = 3,
    parameter int          LOCKOUT_CYCLES  = 50000000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [3:0]  i_Key,
    input  logic        i_Key_Valid,
    output logic        o_Key_Strobe,
    output logic [15:0] o_Digits,
    output logic [2:0]  o_Count,
    output logic        o_Granted,
    output logic        o_Denied,
    output logic        o_Locked
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LIMIT   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [LK_W-1:0] LK_LAST    = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]      FAIL_LIMIT = 3'(MAX_FAILS);

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous keypad inputs
    // ------------------------------------------------------------------
    logic [3:0] key_s1;
    logic [3:0] key_s2;
    logic       vld_s1;
    logic       vld_s2;
    logic [3:0] key_prev;

    // Double-register key and valid, and keep last synced key for the stability compare
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            key_s1   <= 4'h0;
            key_s2   <= 4'h0;
            vld_s1   <= 1'b0;
            vld_s2   <= 1'b0;
            key_prev <= 4'h0;
        end else begin
            key_s1   <= i_Key;
            key_s2   <= key_s1;
            vld_s1   <= i_Key_Valid;
            vld_s2   <= vld_s1;
            key_prev <= key_s2;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: one strobe per physical keystroke
    // ------------------------------------------------------------------
    typedef enum logic {
        DB_RELEASED = 1'b0,
        DB_PRESSED  = 1'b1
    } db_state_t;

    db_state_t       db_state;
    db_state_t       db_state_nxt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic [DB_W-1:0] db_cnt_inc;
    logic [3:0]      key_latched;
    logic [3:0]      key_latched_nxt;
    logic            strobe_nxt;

    // Saturating increment; the state machine leaves each state as soon as the limit is seen
    assign db_cnt_inc = (db_cnt == DB_LIMIT) ? db_cnt : db_cnt + DB_W'(1);

    // Debouncer state, stable-sample counter, latched key and strobe
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            db_state     <= DB_RELEASED;
            db_cnt       <= '0;
            key_latched  <= 4'h0;
            o_Key_Strobe <= 1'b0;
        end else begin
            db_state     <= db_state_nxt;
            db_cnt       <= db_cnt_nxt;
            key_latched  <= key_latched_nxt;
            o_Key_Strobe <= strobe_nxt;
        end
    end

    // Press needs DEBOUNCE_CYCLES samples of valid with an unchanging key;
    // release needs the same number of samples of valid low. A key change
    // while held is invisible because PRESSED only watches valid.
    always_comb begin
        db_state_nxt    = db_state;
        db_cnt_nxt      = db_cnt;
        key_latched_nxt = key_latched;
        strobe_nxt      = 1'b0;
        case (db_state)
            DB_RELEASED: begin
                if (db_cnt == DB_LIMIT) begin
                    strobe_nxt      = 1'b1;
                    key_latched_nxt = key_prev;
                    db_state_nxt    = DB_PRESSED;
                    db_cnt_nxt      = '0;
                end else if (vld_s2 && (key_s2 == key_prev)) begin
                    db_cnt_nxt = db_cnt_inc;
                end else if (vld_s2) begin
                    db_cnt_nxt = DB_W'(1);
                end else begin
                    db_cnt_nxt = '0;
                end
            end
            DB_PRESSED: begin
                if (db_cnt == DB_LIMIT) begin
                    db_state_nxt = DB_RELEASED;
                    db_cnt_nxt   = '0;
                end else if (!vld_s2) begin
                    db_cnt_nxt = db_cnt_inc;
                end else begin
                    db_cnt_nxt = '0;
                end
            end
            default: begin
                db_state_nxt = DB_RELEASED;
                db_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Code entry FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } st_t;

    st_t             state;
    st_t             state_nxt;
    logic [15:0]     digits_nxt;
    logic [2:0]      count_nxt;
    logic [2:0]      fails;
    logic [2:0]      fails_nxt;
    logic [2:0]      fails_inc;
    logic [LK_W-1:0] lk_timer;
    logic [LK_W-1:0] lk_timer_nxt;
    logic            granted_nxt;
    logic            denied_nxt;
    logic            locked_nxt;
    logic            key_is_digit;
    logic            key_is_enter;
    logic            key_is_clear;

    assign key_is_digit = (key_latched <= 4'd9);
    assign key_is_enter = (key_latched == KEY_ENTER);
    assign key_is_clear = (key_latched == KEY_CLEAR);
    assign fails_inc    = fails + 3'd1;

    // Entry state, digit buffer, failure count, lockout timer and result pulses
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= ST_IDLE;
            o_Digits  <= 16'h0000;
            o_Count   <= 3'd0;
            fails     <= 3'd0;
            lk_timer  <= '0;
            o_Granted <= 1'b0;
            o_Denied  <= 1'b0;
            o_Locked  <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_Digits  <= digits_nxt;
            o_Count   <= count_nxt;
            fails     <= fails_nxt;
            lk_timer  <= lk_timer_nxt;
            o_Granted <= granted_nxt;
            o_Denied  <= denied_nxt;
            o_Locked  <= locked_nxt;
        end
    end

    // Key handling, one-cycle compare, and lockout countdown
    always_comb begin
        state_nxt    = state;
        digits_nxt   = o_Digits;
        count_nxt    = o_Count;
        fails_nxt    = fails;
        lk_timer_nxt = lk_timer;
        granted_nxt  = 1'b0;
        denied_nxt   = 1'b0;
        locked_nxt   = o_Locked;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (o_Key_Strobe) begin
                    if (key_is_digit) begin
                        // A fifth digit is dropped so the buffer holds the first four typed
                        if (o_Count < 3'd4) begin
                            digits_nxt = {o_Digits[11:0], key_latched};
                            count_nxt  = o_Count + 3'd1;
                            state_nxt  = ST_ENTRY;
                        end
                    end else if (key_is_clear) begin
                        digits_nxt = 16'h0000;
                        count_nxt  = 3'd0;
                        state_nxt  = ST_IDLE;
                    end else if (key_is_enter && (o_Count == 3'd4)) begin
                        state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                // Strobes are not examined here; CHECK lasts one cycle
                digits_nxt = 16'h0000;
                count_nxt  = 3'd0;
                if (o_Digits == CODE) begin
                    granted_nxt = 1'b1;
                    fails_nxt   = 3'd0;
                    state_nxt   = ST_IDLE;
                end else begin
                    denied_nxt = 1'b1;
                    fails_nxt  = fails_inc;
                    if (fails_inc == FAIL_LIMIT) begin
                        locked_nxt   = 1'b1;
                        lk_timer_nxt = '0;
                        state_nxt    = ST_LOCKOUT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_LOCKOUT: begin
                // Locked rose with the deny pulse; clearing on timer==LOCKOUT_CYCLES-1 gives exactly LOCKOUT_CYCLES high cycles
                if (lk_timer == LK_LAST) begin
                    locked_nxt = 1'b0;
                    fails_nxt  = 3'd0;
                    state_nxt  = ST_IDLE;
                end else begin
                    lk_timer_nxt = lk_timer + LK_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: table-driven keystroke vectors, hand sequences for timing/lockout/reset, and random keystrokes against a queue-based model.
// Latency: checks are taken after each full keystroke (press and debounced release) plus exact strobe-edge timing.
// Backpressure: not applicable; the bench drives level inputs at the falling edge.
`timescale 1ns/1ps
module tb_keypad_code_entry;

    localparam int          DB   = 4;
    localparam int          LK   = 20;
    localparam int          MF   = 3;
    localparam logic [15:0] CODE = 16'h1234;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic [3:0]  i_Key = 4'h0;
    logic        i_Key_Valid = 1'b0;
    logic        o_Key_Strobe;
    logic [15:0] o_Digits;
    logic [2:0]  o_Count;
    logic        o_Granted;
    logic        o_Denied;
    logic        o_Locked;

    keypad_code_entry #(
        .DEBOUNCE_CYCLES (DB),
        .CODE            (CODE),
        .MAX_FAILS       (MF),
        .LOCKOUT_CYCLES  (LK)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Key        (i_Key),
        .i_Key_Valid  (i_Key_Valid),
        .o_Key_Strobe (o_Key_Strobe),
        .o_Digits     (o_Digits),
        .o_Count      (o_Count),
        .o_Granted    (o_Granted),
        .o_Denied     (o_Denied),
        .o_Locked     (o_Locked)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;

    // Edge-sampled event counters
    int   cyc = 0;
    int   strobe_cnt = 0;
    int   grant_cnt = 0;
    int   deny_cnt = 0;
    int   lock_cyc = 0;
    int   last_strobe_cyc = -1;
    logic locked_at_deny = 1'b0;
    logic locked_at_strobe = 1'b0;

    // Count pulses and locked cycles seen at each rising edge
    always @(posedge i_Clk) begin
        cyc <= cyc + 1;
        if (o_Key_Strobe) begin
            strobe_cnt       <= strobe_cnt + 1;
            last_strobe_cyc  <= cyc;
            locked_at_strobe <= o_Locked;
        end
        if (o_Granted) grant_cnt <= grant_cnt + 1;
        if (o_Denied) begin
            deny_cnt       <= deny_cnt + 1;
            locked_at_deny <= o_Locked;
        end
        if (o_Locked) lock_cyc <= lock_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobe"},  32'(o_Key_Strobe), 0);
        check({tag, "_digits"},  32'(o_Digits),     0);
        check({tag, "_count"},   32'(o_Count),      0);
        check({tag, "_granted"}, 32'(o_Granted),    0);
        check({tag, "_denied"},  32'(o_Denied),     0);
        check({tag, "_locked"},  32'(o_Locked),     0);
    endtask

    task automatic keystroke(input logic [3:0] k, input int hold, input int rel);
        @(negedge i_Clk);
        i_Key       = k;
        i_Key_Valid = 1'b1;
        repeat (hold) @(negedge i_Clk);
        i_Key_Valid = 1'b0;
        i_Key       = 4'($urandom_range(0, 15));
        repeat (rel) @(negedge i_Clk);
    endtask

    task automatic press(input logic [3:0] k);
        keystroke(k, DB + 4, DB + 4);
    endtask

    task automatic wait_unlock(input string tag);
        for (int i = 0; i < 60 && o_Locked; i++) @(negedge i_Clk);
        check({tag, "_unlock"}, 32'(o_Locked), 0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
        press(4'hA);
    endtask

    typedef struct {
        logic [3:0]  key;
        int          cnt;
        logic [15:0] dig;
        int          g;
        int          d;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] k, input int c, input logic [15:0] dg, input int g, input int dn);
        vec_t v;
        v.key = k;
        v.cnt = c;
        v.dig = dg;
        v.g   = g;
        v.d   = dn;
        return v;
    endfunction

    vec_t tbl[24];

    // Queue-based model state for the random phase
    int          mq[$];
    int          m_grant;
    int          m_deny;
    int          m_strobe;
    int          m_fails;
    logic [15:0] m_dig;
    int          m_val;
    logic [3:0]  rk;
    logic [15:0] code_v;
    int          r;
    int          hold_n;
    int          rel_n;
    logic        lock_exp;

    int sb;
    int gb;
    int dbc;
    int lb;
    int onset;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Expected state after each keystroke: count, digits, grant delta, deny delta
        tbl[0]  = mk(4'h1, 1, 16'h0001, 0, 0);
        tbl[1]  = mk(4'h2, 2, 16'h0012, 0, 0);
        tbl[2]  = mk(4'h3, 3, 16'h0123, 0, 0);
        tbl[3]  = mk(4'h4, 4, 16'h1234, 0, 0);
        tbl[4]  = mk(4'hA, 0, 16'h0000, 1, 0);
        tbl[5]  = mk(4'h1, 1, 16'h0001, 0, 0);
        tbl[6]  = mk(4'h2, 2, 16'h0012, 0, 0);
        tbl[7]  = mk(4'hC, 0, 16'h0000, 0, 0);
        tbl[8]  = mk(4'h3, 1, 16'h0003, 0, 0);
        tbl[9]  = mk(4'hA, 1, 16'h0003, 0, 0);
        tbl[10] = mk(4'hC, 0, 16'h0000, 0, 0);
        tbl[11] = mk(4'hF, 0, 16'h0000, 0, 0);
        tbl[12] = mk(4'h6, 1, 16'h0006, 0, 0);
        tbl[13] = mk(4'hB, 1, 16'h0006, 0, 0);
        tbl[14] = mk(4'h7, 2, 16'h0067, 0, 0);
        tbl[15] = mk(4'h8, 3, 16'h0678, 0, 0);
        tbl[16] = mk(4'h9, 4, 16'h6789, 0, 0);
        tbl[17] = mk(4'h0, 4, 16'h6789, 0, 0);
        tbl[18] = mk(4'hA, 0, 16'h0000, 0, 1);
        tbl[19] = mk(4'h1, 1, 16'h0001, 0, 0);
        tbl[20] = mk(4'h2, 2, 16'h0012, 0, 0);
        tbl[21] = mk(4'h3, 3, 16'h0123, 0, 0);
        tbl[22] = mk(4'h4, 4, 16'h1234, 0, 0);
        tbl[23] = mk(4'hA, 0, 16'h0000, 1, 0);

        // Reset state
        repeat (3) @(negedge i_Clk);
        check_all_zero("reset");
        i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clk);

        // Table-driven keystrokes
        for (int i = 0; i < 24; i++) begin
            sb  = strobe_cnt;
            gb  = grant_cnt;
            dbc = deny_cnt;
            press(tbl[i].key);
            check($sformatf("row%0d_count", i),  32'(o_Count),  32'(tbl[i].cnt));
            check($sformatf("row%0d_digits", i), 32'(o_Digits), 32'(tbl[i].dig));
            check($sformatf("row%0d_grant", i),  grant_cnt - gb, tbl[i].g);
            check($sformatf("row%0d_deny", i),   deny_cnt - dbc, tbl[i].d);
            check($sformatf("row%0d_strobe", i), strobe_cnt - sb, 1);
        end

        // Three wrong codes: lockout, key ignored during lockout, then grant
        dbc = deny_cnt;
        enter_code(16'h1235);
        check("lk_deny1", deny_cnt - dbc, 1);
        check("lk_deny1_unlocked", 32'(locked_at_deny), 0);
        enter_code(16'h1235);
        check("lk_deny2", deny_cnt - dbc, 2);
        lb = lock_cyc;
        enter_code(16'h1235);
        check("lk_deny3", deny_cnt - dbc, 3);
        check("lk_locked_with_deny", 32'(locked_at_deny), 1);
        check("lk_locked_now", 32'(o_Locked), 1);
        sb = strobe_cnt;
        press(4'h7);
        check("lk_key7_strobe", strobe_cnt - sb, 1);
        check("lk_key7_seen_locked", 32'(locked_at_strobe), 1);
        check("lk_key7_count", 32'(o_Count), 0);
        wait_unlock("lk");
        check("lk_duration", lock_cyc - lb, LK);
        gb = grant_cnt;
        enter_code(CODE);
        check("lk_after_grant", grant_cnt - gb, 1);
        check("lk_after_count", 32'(o_Count), 0);

        // Bouncing valid then stable key 9: one strobe at a fixed edge
        sb = strobe_cnt;
        @(negedge i_Clk);
        i_Key = 4'h9;
        for (int b = 0; b < 2; b++) begin
            i_Key_Valid = 1'b1;
            repeat (2) @(negedge i_Clk);
            i_Key_Valid = 1'b0;
            repeat (2) @(negedge i_Clk);
        end
        i_Key_Valid = 1'b1;
        onset = cyc;
        repeat (12) @(negedge i_Clk);
        i_Key_Valid = 1'b0;
        repeat (8) @(negedge i_Clk);
        check("bounce_one_strobe", strobe_cnt - sb, 1);
        check("bounce_strobe_edge", last_strobe_cyc, onset + DB + 3);
        check("bounce_digit", 32'(o_Digits[3:0]), 9);
        check("bounce_count", 32'(o_Count), 1);

        // Long hold produces one strobe
        press(4'hC);
        sb = strobe_cnt;
        keystroke(4'h5, 100, DB + 4);
        check("hold_one_strobe", strobe_cnt - sb, 1);
        check("hold_count", 32'(o_Count), 1);
        check("hold_digits", 32'(o_Digits), 16'h0005);

        // Reset mid-entry with a key held through reset
        press(4'h1);
        press(4'h2);
        check("rst_entry_pre_count", 32'(o_Count), 3);
        press(4'hC);
        press(4'h1);
        press(4'h2);
        check("rst_entry_count2", 32'(o_Count), 2);
        @(negedge i_Clk);
        i_Key       = 4'h1;
        i_Key_Valid = 1'b1;
        #2;
        i_Rst_n = 1'b0;
        #1;
        check_all_zero("rst_entry");
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        sb = strobe_cnt;
        repeat (10) @(negedge i_Clk);
        i_Key_Valid = 1'b0;
        repeat (8) @(negedge i_Clk);
        check("rst_held_strobe", strobe_cnt - sb, 1);
        check("rst_held_count", 32'(o_Count), 1);
        check("rst_held_digits", 32'(o_Digits), 16'h0001);
        gb = grant_cnt;
        press(4'h2);
        press(4'h3);
        press(4'h4);
        press(4'hA);
        check("rst_entry_grant", grant_cnt - gb, 1);

        // Reset mid-lockout
        enter_code(16'h9999);
        enter_code(16'h9999);
        enter_code(16'h9999);
        check("rst_lk_locked", 32'(o_Locked), 1);
        @(negedge i_Clk);
        #2;
        i_Rst_n = 1'b0;
        #1;
        check_all_zero("rst_lk");
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clk);
        gb = grant_cnt;
        enter_code(CODE);
        check("rst_lk_grant", grant_cnt - gb, 1);
        check("rst_lk_unlocked", 32'(o_Locked), 0);

        // Random keystrokes against the queue model
        m_grant  = grant_cnt;
        m_deny   = deny_cnt;
        m_strobe = strobe_cnt;
        m_fails  = 0;
        mq.delete();
        code_v   = CODE;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                if (mq.size() < 4) rk = code_v[15 - 4 * mq.size() -: 4];
                else rk = 4'hA;
            end else if (r < 65) begin
                rk = 4'hA;
            end else if (r < 72) begin
                rk = 4'hC;
            end else begin
                rk = 4'($urandom_range(0, 15));
            end
            hold_n   = DB + 4 + $urandom_range(0, 4);
            rel_n    = DB + 4 + $urandom_range(0, 4);
            lock_exp = 1'b0;

            m_strobe++;
            if (rk <= 4'd9) begin
                if (mq.size() < 4) mq.push_back(int'(rk));
            end else if (rk == 4'hC) begin
                mq.delete();
            end else if (rk == 4'hA && mq.size() == 4) begin
                m_val = mq[0] * 4096 + mq[1] * 256 + mq[2] * 16 + mq[3];
                if (m_val == int'(CODE)) begin
                    m_grant++;
                    m_fails = 0;
                end else begin
                    m_deny++;
                    m_fails++;
                    if (m_fails == MF) begin
                        lock_exp = 1'b1;
                        m_fails  = 0;
                    end
                end
                mq.delete();
            end

            keystroke(rk, hold_n, rel_n);
            if (lock_exp) begin
                check($sformatf("rnd%0d_locked", n), 32'(o_Locked), 1);
                wait_unlock($sformatf("rnd%0d", n));
            end

            m_dig = 16'h0000;
            foreach (mq[j]) m_dig = {m_dig[11:0], 4'(mq[j])};
            check($sformatf("rnd%0d_count", n),  32'(o_Count),  mq.size());
            check($sformatf("rnd%0d_digits", n), 32'(o_Digits), 32'(m_dig));
            check($sformatf("rnd%0d_grants", n), grant_cnt,  m_grant);
            check($sformatf("rnd%0d_denies", n), deny_cnt,   m_deny);
            check($sformatf("rnd%0d_strobes", n), strobe_cnt, m_strobe);
            check($sformatf("rnd%0d_nolock", n), 32'(o_Locked), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
